// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the mips_32 result-checking harness.
package mips_tb_pkg;

    // Run sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Capture-event selection
    localparam int unsigned CAP_CHANGE = 0;
    localparam int unsigned CAP_EVERY  = 1;

endpackage

// File: rtl/mips_exp_mem.sv
// Expected-value register file: synchronous write, combinational read.
module mips_exp_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_in_range;
    logic              rd_in_range;

    // Address range qualification; only needed when DEPTH is not a power of two
    generate
        if (DEPTH == (1 << AW)) begin : g_full
            assign wr_in_range = 1'b1;
            assign rd_in_range = 1'b1;
        end else begin : g_partial
            assign wr_in_range = (32'(wr_addr) < DEPTH);
            assign rd_in_range = (32'(rd_addr) < DEPTH);
        end
    endgenerate

    // Storage is deliberately not reset so contents survive a harness reset
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read of the entry currently being checked
    assign rd_data = rd_in_range ? mem[rd_addr] : '0;

endmodule

// File: rtl/mips_result_checker.sv
// Self-checking run harness for mips_32: sequences core reset, compares
// each new result against a preloaded expected sequence, with a watchdog.
module mips_result_checker
    import mips_tb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned RESET_CYCLES = 5,
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned CAPTURE_MODE = 0,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              exp_wr_en,
    input  logic [AW-1:0]     exp_wr_addr,
    input  logic [DATA_W-1:0] exp_wr_data,
    input  logic [CW-1:0]     exp_count,
    input  logic [DATA_W-1:0] result,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CW-1:0]     err_index,
    output logic [DATA_W-1:0] err_value,
    output logic [CW-1:0]     match_count
);

    localparam int unsigned HW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t            state, state_d;
    logic [HW-1:0]     hold_cnt;
    logic [TW-1:0]     wdog;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     idx;
    logic [CW-1:0]     idx_inc;
    logic [DATA_W-1:0] prev;
    logic [DATA_W-1:0] exp_rd;
    logic              mem_we;

    logic start_acc, hold_last, zero_pass;
    logic ev_match, ev_last, ev_fail, ev_to, event_c;

    // Entries matched so far doubles as the index of the entry under test
    assign idx     = match_count;
    assign idx_inc = idx + CW'(1);
    assign mem_we  = exp_wr_en && ((state == ST_IDLE) || (state == ST_DONE));
    assign event_c = (CAPTURE_MODE == CAP_EVERY) ? 1'b1 : (result != prev);

    mips_exp_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_exp_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (exp_wr_addr),
        .wr_data (exp_wr_data),
        .rd_addr (AW'(idx)),
        .rd_data (exp_rd)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and per-cycle decision strobes
    always_comb begin
        state_d   = state;
        start_acc = 1'b0;
        hold_last = 1'b0;
        zero_pass = 1'b0;
        ev_match  = 1'b0;
        ev_last   = 1'b0;
        ev_fail   = 1'b0;
        ev_to     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    hold_last = 1'b1;
                    if (count_q == '0) begin
                        zero_pass = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (event_c) begin
                    if (result == exp_rd) begin
                        ev_match = 1'b1;
                        if (idx_inc == count_q) begin
                            ev_last = 1'b1;
                            state_d = ST_DONE;
                        end
                    end else begin
                        ev_fail = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (wdog == TW'(TIMEOUT - 1)) begin
                    ev_to   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counters, sampled result, verdict and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            err_index   <= '0;
            err_value   <= '0;
            match_count <= '0;
            count_q     <= '0;
            hold_cnt    <= '0;
            wdog        <= '0;
            prev        <= '0;
        end else begin
            core_reset <= (state_d != ST_RUN);
            busy       <= (state_d == ST_HOLD) || (state_d == ST_RUN);
            done       <= (state_d == ST_DONE);
            prev       <= result;

            if (start_acc) begin
                count_q     <= exp_count;
                match_count <= '0;
                pass        <= 1'b0;
                fail        <= 1'b0;
                timeout     <= 1'b0;
                err_index   <= '0;
                err_value   <= '0;
                hold_cnt    <= HW'(RESET_CYCLES - 1);
            end else if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            if (hold_last || ev_match) begin
                wdog <= '0;
            end else if ((state == ST_RUN) && !event_c) begin
                wdog <= wdog + TW'(1);
            end

            if (ev_match) begin
                match_count <= idx_inc;
            end
            if (ev_last || zero_pass) begin
                pass <= 1'b1;
            end
            if (ev_fail || ev_to) begin
                fail      <= 1'b1;
                timeout   <= ev_to;
                err_index <= idx;
                err_value <= result;
            end
        end
    end

endmodule
